// File: rtl/post_adder_carryout.sv
// 48-bit post-adder with accumulator feedback, carry/borrow out, a saturating carry-event
// counter and sticky flag. PREG/CARRYOUTREG select registered or combinational result paths.
module post_adder_carryout #(
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1
) (
    input  logic        CLK,
    input  logic        RSTP_N,
    input  logic        CEP,
    input  logic        CECARRYOUT,
    input  logic [47:0] X,
    input  logic [47:0] Z,
    input  logic        CIN,
    input  logic        SUB,
    input  logic        ACCUM,
    input  logic        VALID_IN,
    input  logic        CLR_CNT,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic        CARRYOUT,
    output logic        CARRYOUTF,
    output logic        VALID_OUT,
    output logic [7:0]  CARRY_CNT,
    output logic        OVF_STICKY
);

    logic [47:0] r_acc;
    logic        r_cout;
    logic        r_valid;
    logic [7:0]  r_cnt;
    logic        r_sticky;

    logic [47:0] w_zsel;
    logic [48:0] w_rhs;
    logic [48:0] w_sum;
    logic        w_evt;
    logic [7:0]  w_cnt_nxt;
    logic        w_sticky_nxt;

    // Operand select and 49-bit add/subtract; bit 48 is carry on add, borrow on subtract.
    always_comb begin
        w_zsel = Z;
        w_rhs  = {1'b0, X} + {48'd0, CIN};
        w_sum  = 49'd0;
        if (ACCUM) begin
            w_zsel = r_acc;
        end else begin
            w_zsel = Z;
        end
        if (SUB) begin
            w_sum = {1'b0, w_zsel} - w_rhs;
        end else begin
            w_sum = {1'b0, w_zsel} + w_rhs;
        end
    end

    assign w_evt = CECARRYOUT & w_sum[48] & VALID_IN;

    // Carry counter / sticky next state: a clear coincident with an event restarts at one.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_sticky_nxt = r_sticky;
        if (CLR_CNT) begin
            w_cnt_nxt    = w_evt ? 8'd1 : 8'd0;
            w_sticky_nxt = w_evt;
        end else if (w_evt) begin
            w_cnt_nxt    = (r_cnt == 8'hFF) ? 8'hFF : (r_cnt + 8'd1);
            w_sticky_nxt = 1'b1;
        end else begin
            w_cnt_nxt    = r_cnt;
            w_sticky_nxt = r_sticky;
        end
    end

    // Accumulator and valid pipe, enabled by CEP.
    always_ff @(posedge CLK) begin
        if (!RSTP_N) begin
            r_acc   <= 48'd0;
            r_valid <= 1'b0;
        end else if (CEP) begin
            r_acc   <= w_sum[47:0];
            r_valid <= VALID_IN;
        end else begin
            r_acc   <= r_acc;
            r_valid <= r_valid;
        end
    end

    // Carry-out register, counter and sticky flag, enabled by CECARRYOUT.
    always_ff @(posedge CLK) begin
        if (!RSTP_N) begin
            r_cout   <= 1'b0;
            r_cnt    <= 8'd0;
            r_sticky <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_sticky <= w_sticky_nxt;
            if (CECARRYOUT) begin
                r_cout <= w_sum[48];
            end else begin
                r_cout <= r_cout;
            end
        end
    end

    // Output path selection between registered and combinational results.
    always_comb begin
        P         = w_sum[47:0];
        VALID_OUT = VALID_IN;
        CARRYOUT  = w_sum[48];
        if (PREG != 0) begin
            P         = r_acc;
            VALID_OUT = r_valid;
        end else begin
            P         = w_sum[47:0];
            VALID_OUT = VALID_IN;
        end
        if (CARRYOUTREG != 0) begin
            CARRYOUT = r_cout;
        end else begin
            CARRYOUT = w_sum[48];
        end
    end

    assign PCOUT      = P;
    assign CARRYOUTF  = CARRYOUT;
    assign CARRY_CNT  = r_cnt;
    assign OVF_STICKY = r_sticky;

endmodule

// File: tb/tb_post_adder_carryout.sv
// Bench for post_adder_carryout: registered and combinational builds side by side,
// checked against an arithmetic reference model, fixed vectors and corner sequences.
module tb_post_adder_carryout;

    logic        clk = 1'b0;
    logic        rstp_n, cep, ceco, cin, sub, accum, vin, clr;
    logic [47:0] x, z;

    logic [47:0] p1, pc1, p0, pc0;
    logic        co1, cof1, vo1, st1, co0, cof0, vo0, st0;
    logic [7:0]  cnt1, cnt0;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [47:0] m_acc;
    bit          m_cout, m_valid, m_sticky;
    int          m_cnt;

    always #5 clk = ~clk;

    post_adder_carryout #(.PREG(1), .CARRYOUTREG(1)) dut (
        .CLK(clk), .RSTP_N(rstp_n), .CEP(cep), .CECARRYOUT(ceco), .X(x), .Z(z),
        .CIN(cin), .SUB(sub), .ACCUM(accum), .VALID_IN(vin), .CLR_CNT(clr),
        .P(p1), .PCOUT(pc1), .CARRYOUT(co1), .CARRYOUTF(cof1), .VALID_OUT(vo1),
        .CARRY_CNT(cnt1), .OVF_STICKY(st1));

    post_adder_carryout #(.PREG(0), .CARRYOUTREG(0)) dut0 (
        .CLK(clk), .RSTP_N(rstp_n), .CEP(cep), .CECARRYOUT(ceco), .X(x), .Z(z),
        .CIN(cin), .SUB(sub), .ACCUM(accum), .VALID_IN(vin), .CLR_CNT(clr),
        .P(p0), .PCOUT(pc0), .CARRYOUT(co0), .CARRYOUTF(cof0), .VALID_OUT(vo0),
        .CARRY_CNT(cnt0), .OVF_STICKY(st0));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wide sum: carry when the true sum reaches 2^48, borrow when the subtrahend is larger.
    function automatic void ref_sum(input logic [47:0] zs, input logic [47:0] xv,
                                    input bit c, input bit s,
                                    output logic [47:0] r, output bit co);
        longint unsigned a, b, t;
        a = 64'(zs);
        b = 64'(xv);
        if (!s) begin
            t  = a + b + 64'(c);
            co = (t >= 64'h0001_0000_0000_0000);
            r  = 48'(t);
        end else begin
            t  = b + 64'(c);
            co = (a < t);
            r  = 48'(a - t);
        end
    endfunction

    // One clock: check combinational build before the edge, registered build after it.
    task automatic cycle();
        logic [47:0] r;
        bit          c, evt;
        ref_sum(accum ? m_acc : z, x, cin, sub, r, c);
        @(negedge clk);
        chk("p_comb", p0, r);
        chk("co_comb", co0, c);
        chk("vo_comb", vo0, vin);
        chk("pcout_comb", pc0, p0);
        chk("coutf_comb", cof0, co0);
        @(posedge clk);
        if (!rstp_n) begin
            m_acc = 48'd0; m_cout = 1'b0; m_valid = 1'b0; m_cnt = 0; m_sticky = 1'b0;
        end else begin
            evt = ceco && c && vin;
            if (cep) begin
                m_acc   = r;
                m_valid = vin;
            end
            if (ceco) m_cout = c;
            if (clr) begin
                m_cnt    = evt ? 1 : 0;
                m_sticky = evt;
            end else if (evt) begin
                m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_sticky = 1'b1;
            end
        end
        #1;
        chk("p_reg", p1, m_acc);
        chk("co_reg", co1, m_cout);
        chk("vo_reg", vo1, m_valid);
        chk("cnt", cnt1, m_cnt);
        chk("sticky", st1, m_sticky);
        chk("cnt_build0", cnt0, m_cnt);
        chk("pcout_reg", pc1, p1);
        chk("coutf_reg", cof1, co1);
    endtask

    task automatic set_in(input logic [47:0] xv, input logic [47:0] zv, input bit c,
                          input bit s, input bit ac);
        x = xv; z = zv; cin = c; sub = s; accum = ac;
    endtask

    task automatic do_reset();
        rstp_n = 1'b0;
        cycle();
        rstp_n = 1'b1;
    endtask

    typedef struct {
        logic [47:0] x;
        logic [47:0] z;
        bit          cin;
        bit          sub;
        logic [47:0] exp_p;
        bit          exp_co;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{48'hFFFF_FFFF_FFFF, 48'd0, 1'b1, 1'b0, 48'd0, 1'b1};
        vecs[1] = '{48'd7, 48'd5, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFE, 1'b1};
        vecs[2] = '{48'd5, 48'd7, 1'b0, 1'b1, 48'd2, 1'b0};
        vecs[3] = '{48'd20, 48'd10, 1'b1, 1'b0, 48'd31, 1'b0};
        vecs[4] = '{48'd0, 48'd0, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1};
        vecs[5] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b0, 48'd0, 1'b1};
        vecs[6] = '{48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 1'b0, 1'b1, 48'd0, 1'b0};

        m_acc = 48'd0; m_cout = 1'b0; m_valid = 1'b0; m_cnt = 0; m_sticky = 1'b0;
        rstp_n = 1'b1; cep = 1'b1; ceco = 1'b1; vin = 1'b1; clr = 1'b0;
        set_in(48'd0, 48'd0, 1'b0, 1'b0, 1'b0);

        // reset state
        do_reset();
        chk("rst_p", p1, 48'd0);
        chk("rst_co", co1, 1'b0);
        chk("rst_vo", vo1, 1'b0);
        chk("rst_cnt", cnt1, 8'd0);
        chk("rst_sticky", st1, 1'b0);

        // add carry straight after reset
        set_in(48'hFFFF_FFFF_FFFF, 48'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("addc_p", p1, 48'd0);
        chk("addc_co", co1, 1'b1);
        chk("addc_cnt", cnt1, 8'd1);
        chk("addc_sticky", st1, 1'b1);

        // fixed vectors
        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].x, vecs[i].z, vecs[i].cin, vecs[i].sub, 1'b0);
            cycle();
            chk($sformatf("vec%0d_p", i), p1, vecs[i].exp_p);
            chk($sformatf("vec%0d_co", i), co1, vecs[i].exp_co);
        end

        // accumulate from zero, then hold with CEP low
        do_reset();
        set_in(48'd3, 48'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk($sformatf("acc_step%0d", i), p1, 48'(3 * i));
        end
        cep = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("acc_hold", p1, 48'd12);
        end
        cep = 1'b1;

        // reset pulse between edges changes nothing
        @(negedge clk);
        rstp_n = 1'b0;
        #2;
        chk("rst_between_p", p1, 48'd12);
        rstp_n = 1'b1;
        cep = 1'b0;
        cycle();
        chk("rst_between_after", p1, 48'd12);
        cep = 1'b1;

        // saturation and clear behaviour
        set_in(48'hFFFF_FFFF_FFFF, 48'd0, 1'b1, 1'b0, 1'b0);
        clr = 1'b1; vin = 1'b0;
        cycle();
        clr = 1'b0; vin = 1'b1;
        for (int i = 0; i < 260; i++) cycle();
        chk("sat_cnt", cnt1, 8'd255);
        clr = 1'b1; vin = 1'b0;
        cycle();
        chk("clr_cnt", cnt1, 8'd0);
        chk("clr_sticky", st1, 1'b0);
        vin = 1'b1;
        cycle();
        chk("clr_evt_cnt", cnt1, 8'd1);
        chk("clr_evt_sticky", st1, 1'b1);
        clr = 1'b0;

        // mid-accumulation reset
        do_reset();
        set_in(48'd100, 48'd0, 1'b0, 1'b0, 1'b1);
        cycle();
        chk("mid_acc", p1, 48'd100);
        do_reset();
        chk("mid_rst_p", p1, 48'd0);
        chk("mid_rst_vo", vo1, 1'b0);
        set_in(48'd1, 48'd0, 1'b0, 1'b0, 1'b1);
        cycle();
        chk("mid_after", p1, 48'd1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rstp_n = ($urandom_range(0, 49) != 0);
            cep    = ($urandom_range(0, 3) != 0);
            ceco   = ($urandom_range(0, 3) != 0);
            vin    = ($urandom_range(0, 4) != 0);
            clr    = ($urandom_range(0, 19) == 0);
            x      = {$urandom, $urandom} & 64'h0000_FFFF_FFFF_FFFF;
            z      = {$urandom, $urandom} & 64'h0000_FFFF_FFFF_FFFF;
            if ($urandom_range(0, 3) == 0) x = 48'hFFFF_FFFF_FFFF;
            cin    = $urandom_range(0, 1);
            sub    = $urandom_range(0, 1);
            accum  = $urandom_range(0, 1);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
